// File: rtl/mmio_fifo_csr_if.sv
// MMIO request/response bundle for the FIFO CSR block.
// Master drives requests, slave returns one-cycle read responses.
interface mmio_fifo_csr_if #(
    parameter int ADDR_W = 16,
    parameter int TID_W  = 9
);
    logic              mmio_wr_vld;
    logic              mmio_rd_vld;
    logic [ADDR_W-1:0] mmio_addr;
    logic [TID_W-1:0]  mmio_tid;
    logic [63:0]       mmio_wdata;
    logic              rsp_valid;
    logic [TID_W-1:0]  rsp_tid;
    logic [63:0]       rsp_data;

    modport master (
        output mmio_wr_vld, mmio_rd_vld, mmio_addr, mmio_tid, mmio_wdata,
        input  rsp_valid, rsp_tid, rsp_data
    );

    modport slave (
        input  mmio_wr_vld, mmio_rd_vld, mmio_addr, mmio_tid, mmio_wdata,
        output rsp_valid, rsp_tid, rsp_data
    );
endinterface

// File: rtl/mmio_fifo_csr.sv
// MMIO-mapped circular FIFO with status, control and peek registers.
// Push by write to BASE, pop by read of BASE; sticky OVF/UNF flags.
module mmio_fifo_csr #(
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 8,
    parameter int                ADDR_W    = 16,
    parameter int                TID_W     = 9,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mmio_fifo_csr_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0] A_BASE = BASE_ADDR;
    localparam logic [ADDR_W-1:0] A_STAT = BASE_ADDR + ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CTRL = BASE_ADDR + ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_PEEK = BASE_ADDR + ADDR_W'(6);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              ovf;
    logic              unf;

    logic              rd_op;
    logic              wr_op;
    logic              hit_base;
    logic              hit_stat;
    logic              hit_ctrl;
    logic              hit_peek;
    logic              push;
    logic              pop;
    logic              flush;
    logic              clr;
    logic              ovf_set;
    logic              unf_set;
    logic              rd_hit;
    logic [63:0]       head_ext;
    logic [63:0]       status_word;
    logic [63:0]       rd_word;
    logic [CW-1:0]     cnt_next;

    // Decode the request into queue operations; a read wins over a
    // simultaneous write, which is then dropped without side effects.
    always_comb begin
        rd_op    = bus.mmio_rd_vld;
        wr_op    = bus.mmio_wr_vld & ~bus.mmio_rd_vld;
        hit_base = (bus.mmio_addr == A_BASE);
        hit_stat = (bus.mmio_addr == A_STAT);
        hit_ctrl = (bus.mmio_addr == A_CTRL);
        hit_peek = (bus.mmio_addr == A_PEEK);
        push     = wr_op & hit_base & ~full;
        ovf_set  = wr_op & hit_base & full;
        pop      = rd_op & hit_base & ~empty;
        unf_set  = rd_op & hit_base & empty;
        flush    = wr_op & hit_ctrl & bus.mmio_wdata[0];
        clr      = wr_op & hit_ctrl & bus.mmio_wdata[1];
        rd_hit   = rd_op & (hit_base | hit_stat | hit_peek);
    end

    // Build read data from pre-update state; head reads as zero when empty.
    always_comb begin
        head_ext = '0;
        if (!empty) begin
            head_ext[DATA_W-1:0] = mem[rd_ptr];
        end
        status_word = {32'b0, 16'(count), 12'b0, unf, ovf, full, empty};
        rd_word     = '0;
        unique case (1'b1)
            hit_base: rd_word = head_ext;
            hit_peek: rd_word = head_ext;
            hit_stat: rd_word = status_word;
            default:  rd_word = '0;
        endcase
    end

    // Next occupancy; push and pop never coincide since a read drops the write.
    always_comb begin
        cnt_next = count;
        if (flush) begin
            cnt_next = '0;
        end else if (push) begin
            cnt_next = count + CW'(1);
        end else if (pop) begin
            cnt_next = count - CW'(1);
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.mmio_wdata[DATA_W-1:0];
        end
    end

    // Pointers wrap at DEPTH-1 by compare so any depth works.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
        end
    end

    // Registered occupancy and flags, changing only on push/pop/flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (push | pop | flush) begin
            count <= cnt_next;
            full  <= (cnt_next == CW'(DEPTH));
            empty <= (cnt_next == '0);
        end
    end

    // Sticky error flags, cleared only by CTRL bit1 or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (ovf_set) ovf <= 1'b1;
            if (unf_set) unf <= 1'b1;
        end
    end

    // One-cycle response for mapped reads; zero when idle so it ORs cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_tid   <= '0;
            bus.rsp_data  <= '0;
        end else if (rd_hit) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_tid   <= bus.mmio_tid;
            bus.rsp_data  <= rd_word;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_tid   <= '0;
            bus.rsp_data  <= '0;
        end
    end
endmodule

// File: tb/tb_mmio_fifo_csr.sv
// Testbench for mmio_fifo_csr: vector table on a depth-8 instance,
// plus async reset and wrap-around sequences on a depth-5 instance.
module tb_mmio_fifo_csr;
    localparam logic [15:0] BASE = 16'h0020;
    localparam logic [15:0] STAT = 16'h0022;
    localparam logic [15:0] CTRL = 16'h0024;
    localparam logic [15:0] PEEK = 16'h0026;

    logic       clk;
    logic       rst_n;
    logic [3:0] count8;
    logic       full8;
    logic       empty8;
    logic [2:0] count5;
    logic       full5;
    logic       empty5;

    int nchecks = 0;
    int nerr    = 0;

    mmio_fifo_csr_if #(.ADDR_W(16), .TID_W(9)) b8 ();
    mmio_fifo_csr_if #(.ADDR_W(16), .TID_W(9)) b5 ();

    mmio_fifo_csr #(.DATA_W(64), .DEPTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8.slave),
        .count (count8),
        .full  (full8),
        .empty (empty8)
    );

    mmio_fifo_csr #(.DATA_W(64), .DEPTH(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b5.slave),
        .count (count5),
        .full  (full5),
        .empty (empty5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [15:0] addr;
        logic [63:0] wdata;
        bit          ev;
        logic [63:0] ed;
        int          ec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit wr, bit rd, logic [15:0] a,
                                logic [63:0] d, bit ev,
                                logic [63:0] ed, int ec);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d;
        v.ev = ev; v.ed = ed; v.ec = ec;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step8(bit wr, bit rd, logic [15:0] a,
                         logic [63:0] d, logic [8:0] tid);
        @(negedge clk);
        b8.mmio_wr_vld = wr;
        b8.mmio_rd_vld = rd;
        b8.mmio_addr   = a;
        b8.mmio_wdata  = d;
        b8.mmio_tid    = tid;
        @(posedge clk);
        #1;
    endtask

    task automatic step5(bit wr, bit rd, logic [15:0] a,
                         logic [63:0] d, logic [8:0] tid);
        @(negedge clk);
        b5.mmio_wr_vld = wr;
        b5.mmio_rd_vld = rd;
        b5.mmio_addr   = a;
        b5.mmio_wdata  = d;
        b5.mmio_tid    = tid;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int q[$];
        int ec;
        int ex;
        bit do_pop;
        logic [8:0] tid;

        rst_n = 1'b0;
        b8.mmio_wr_vld = 0; b8.mmio_rd_vld = 0; b8.mmio_addr = '0;
        b8.mmio_wdata = '0; b8.mmio_tid = '0;
        b5.mmio_wr_vld = 0; b5.mmio_rd_vld = 0; b5.mmio_addr = '0;
        b5.mmio_wdata = '0; b5.mmio_tid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // async reset mid-stream, with a response in flight
        for (int i = 1; i <= 3; i++) step8(1, 0, BASE, 64'(i), 0);
        step8(0, 1, STAT, 0, 9'h5);
        chk("pre_rst_valid", 64'(b8.rsp_valid), 64'd1);
        chk("pre_rst_count", 64'(count8), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(b8.rsp_valid), 64'd0);
        chk("rst_count", 64'(count8), 64'd0);
        chk("rst_empty", 64'(empty8), 64'd1);
        chk("rst_full", 64'(full8), 64'd0);
        @(negedge clk);
        b8.mmio_rd_vld = 0;
        rst_n = 1'b1;

        // vector table for depth 8
        vecs.push_back(mk(0, 1, STAT, 0, 1, 64'h1, 0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1, 0, BASE, 64'(i), 0, 0, i));
        vecs.push_back(mk(0, 1, STAT, 0, 1, 64'h0008_0002, 8));
        vecs.push_back(mk(1, 0, BASE, 64'hDEAD, 0, 0, 8));
        vecs.push_back(mk(0, 1, STAT, 0, 1, 64'h0008_0006, 8));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, BASE, 0, 1, 64'(i), 8 - i));
        vecs.push_back(mk(0, 1, STAT, 0, 1, 64'h5, 0));
        vecs.push_back(mk(0, 1, BASE, 0, 1, 64'h0, 0));
        vecs.push_back(mk(0, 1, STAT, 0, 1, 64'hD, 0));
        vecs.push_back(mk(1, 0, BASE, 64'hA5, 0, 0, 1));
        vecs.push_back(mk(0, 1, PEEK, 0, 1, 64'hA5, 1));
        vecs.push_back(mk(0, 1, PEEK, 0, 1, 64'hA5, 1));
        vecs.push_back(mk(0, 1, STAT, 0, 1, 64'h0001_000C, 1));
        vecs.push_back(mk(0, 1, BASE, 0, 1, 64'hA5, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, BASE, 64'(16 + i), 0, 0, i + 1));
        vecs.push_back(mk(1, 0, CTRL, 64'h1, 0, 0, 0));
        vecs.push_back(mk(0, 1, STAT, 0, 1, 64'hD, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, BASE, 64'(32 + i), 0, 0, i + 1));
        vecs.push_back(mk(1, 0, CTRL, 64'h3, 0, 0, 0));
        vecs.push_back(mk(0, 1, STAT, 0, 1, 64'h1, 0));
        vecs.push_back(mk(0, 1, 16'h0030, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, BASE, 64'h77, 0, 0, 1));
        vecs.push_back(mk(1, 1, BASE, 64'h99, 1, 64'h77, 0));
        vecs.push_back(mk(0, 1, STAT, 0, 1, 64'h1, 0));
        vecs.push_back(mk(1, 0, STAT, 64'hFF, 0, 0, 0));
        vecs.push_back(mk(1, 0, PEEK, 64'hFF, 0, 0, 0));
        vecs.push_back(mk(0, 1, STAT, 0, 1, 64'h1, 0));

        foreach (vecs[i]) begin
            tid = 9'(i * 3 + 7);
            step8(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, tid);
            chk($sformatf("v%0d_valid", i), 64'(b8.rsp_valid),
                64'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_data", i), b8.rsp_data, vecs[i].ed);
                chk($sformatf("v%0d_tid", i), 64'(b8.rsp_tid), 64'(tid));
            end
            chk($sformatf("v%0d_count", i), 64'(count8), 64'(vecs[i].ec));
            chk($sformatf("v%0d_full", i), 64'(full8),
                64'(vecs[i].ec == 8));
            chk($sformatf("v%0d_empty", i), 64'(empty8),
                64'(vecs[i].ec == 0));
        end
        step8(0, 0, '0, '0, '0);

        // depth 5: interleaved traffic across pointer wrap
        for (int i = 0; i < 23; i++) begin
            ec = q.size();
            if (ec == 5) do_pop = 1;
            else if (ec == 0) do_pop = 0;
            else do_pop = ((i * 7) % 5) >= 3;
            tid = 9'(i * 5 + 1);
            if (do_pop) begin
                ex = q.pop_front();
                step5(0, 1, BASE, 0, tid);
                chk($sformatf("w%0d_valid", i), 64'(b5.rsp_valid), 64'd1);
                chk($sformatf("w%0d_data", i), b5.rsp_data, 64'(ex));
                chk($sformatf("w%0d_tid", i), 64'(b5.rsp_tid), 64'(tid));
            end else begin
                q.push_back(256 + i);
                step5(1, 0, BASE, 64'(256 + i), tid);
                chk($sformatf("w%0d_valid", i), 64'(b5.rsp_valid), 64'd0);
            end
            chk($sformatf("w%0d_count", i), 64'(count5), 64'(q.size()));
            chk($sformatf("w%0d_full", i), 64'(full5), 64'(q.size() == 5));
        end
        step5(0, 0, '0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerr);
        $finish;
    end
endmodule
